down_counter_timer: RTL and testbench

- Programmable down-counting timer with prescaler, reload register and one-shot/periodic modes.
- Complements the up-counting `counter` element: counts toward zero and signals expiry.
- Used as a generic SoC timer and timeout source next to the multicycle core (watchdog, bus timeouts, periodic tick for the OS).

---
 rtl/down_counter_timer.sv | 108 ++++++++++
 tb/tb_down_counter_timer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Programmable down-counting timer: prescaler, reload register, one-shot/periodic expiry.
// Optional sticky interrupt enabled by defining DOWN_COUNTER_TIMER_STICKY_IRQ_EN.
module down_counter_timer #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      periodic,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      irq_clr,
  output logic [WIDTH-1:0]          q,
  output logic                      running,
  output logic                      expired,
  output logic                      irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [WIDTH-1:0]          reload_r;
  logic [WIDTH-1:0]          q_nxt;
  logic [PRESCALE_WIDTH-1:0] pcnt, pcnt_nxt;
  logic                      tick;
  logic                      terminal;
  logic                      expired_nxt;

  // Decrement that never wraps below zero.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  always_comb begin
    // >= rather than == so a prescale lowered mid-run ticks at once instead of wrapping
    tick        = (state == S_RUN) && !stop && (pcnt >= prescale);
    terminal    = tick && (q == '0);
    expired_nxt = terminal && !load;

    state_nxt = state;
    case (state)
      S_IDLE: if (start && !stop) state_nxt = S_RUN;
      S_RUN: begin
        if (stop)                          state_nxt = S_IDLE;
        else if (expired_nxt && !periodic) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (stop)       state_nxt = S_IDLE;
        else if (start) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase

    q_nxt = q;
    if (load)
      q_nxt = load_value;
    else if ((state == S_DONE) && start && !stop)
      q_nxt = reload_r;
    else if (tick)
      q_nxt = terminal ? (periodic ? reload_r : '0) : sat_dec(q);

    pcnt_nxt = pcnt;
    if (load || stop || (start && (state != S_RUN)))
      pcnt_nxt = '0;
    else if (state == S_RUN)
      pcnt_nxt = tick ? '0 : pcnt + PRESCALE_WIDTH'(1);
  end

  // Register stage: counter state and registered expiry pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      q        <= '0;
      reload_r <= '0;
      pcnt     <= '0;
      expired  <= 1'b0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      pcnt    <= pcnt_nxt;
      expired <= expired_nxt;
      if (load) reload_r <= load_value;
    end
  end

  assign running = (state == S_RUN);

`ifdef DOWN_COUNTER_TIMER_STICKY_IRQ_EN
  // A new expiry beats a coincident clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset)            irq <= 1'b0;
    else if (expired_nxt) irq <= 1'b1;
    else if (irq_clr)     irq <= 1'b0;
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = expired;
`endif

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus randomized run vs. a reference model.
module tb_down_counter_timer;

  localparam int W  = 32;
  localparam int PW = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0, irq_clr = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  q;
  logic          running, expired, irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           m_mode = M_IDLE;
  logic [W-1:0] m_q = '0, m_reload = '0;
  int           m_pcnt = 0;
  logic         m_exp = 1'b0, m_irq = 1'b0;

  down_counter_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .start(start),
    .stop(stop), .periodic(periodic), .prescale(prescale), .irq_clr(irq_clr),
    .q(q), .running(running), .expired(expired), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  // Timer behaviour from its rules: one count per (prescale+1) running cycles, expiry at zero.
  task automatic model_update();
    logic         tk, term, fire;
    int           nm;
    logic [W-1:0] nq;
    if (reset) begin
      m_mode = M_IDLE; m_q = '0; m_reload = '0; m_pcnt = 0; m_exp = 0; m_irq = 0;
      return;
    end
    tk   = (m_mode == M_RUN) && !stop && (m_pcnt >= int'(prescale));
    term = tk && (m_q == 0);
    fire = term && !load;
    nm = m_mode;
    if (m_mode == M_IDLE && start && !stop) nm = M_RUN;
    else if (m_mode != M_IDLE && stop) nm = M_IDLE;
    else if (m_mode == M_DONE && start) nm = M_RUN;
    else if (m_mode == M_RUN && fire && !periodic) nm = M_DONE;
    if (load) nq = load_value;
    else if (m_mode == M_DONE && start && !stop) nq = m_reload;
    else if (tk && m_q > 0) nq = m_q - 1;
    else if (term) nq = periodic ? m_reload : 0;
    else nq = m_q;
    if (load || stop || (start && m_mode != M_RUN)) m_pcnt = 0;
    else if (m_mode == M_RUN) m_pcnt = tk ? 0 : m_pcnt + 1;
    if (load) m_reload = load_value;
`ifdef DOWN_COUNTER_TIMER_STICKY_IRQ_EN
    if (fire) m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
`else
    m_irq = fire;
`endif
    m_mode = nm; m_q = nq; m_exp = fire;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_tests++;
    if ({q, running, expired, irq} !== {32'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_values: got q=%0d run=%b exp=%b irq=%b, want all 0", q, running, expired, irq);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if ({q, running, expired, irq} !== {32'd0, 3'b000}) begin
        n_fail++; $display("FAIL idle_hold cycle %0d: got q=%0d run=%b exp=%b irq=%b, want all 0", i, q, running, expired, irq);
      end
    end
  endtask

  task automatic test_oneshot();
    prescale = 0; periodic = 0; load = 1; load_value = 5;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    n_tests++;
    if (q !== 5 || running !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_start: got q=%0d run=%b, want q=5 run=1", q, running);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      n_tests++;
      if (q !== W'(5 - i) || expired !== 1'b0) begin
        n_fail++; $display("FAIL oneshot_count %0d: got q=%0d exp=%b, want q=%0d exp=0", i, q, expired, 5 - i);
      end
    end
    step();
    n_tests++;
    if (q !== 0 || expired !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_expire: got q=%0d exp=%b run=%b, want q=0 exp=1 run=0", q, expired, running);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (q !== 0 || expired !== 1'b0 || running !== 1'b0) begin
        n_fail++; $display("FAIL oneshot_done %0d: got q=%0d exp=%b run=%b, want q=0 exp=0 run=0", i, q, expired, running);
      end
    end
  endtask

  task automatic test_periodic_prescale();
    int cnt;
    prescale = 3; periodic = 1; load = 1; load_value = 2;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    for (int p = 0; p < 3; p++) begin
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        step(); cnt++;
        if (expired) break;
      end
      n_tests++;
      if (cnt !== 12 || q !== 2 || running !== 1'b1) begin
        n_fail++; $display("FAIL periodic_period %0d: got cycles=%0d q=%0d run=%b, want cycles=12 q=2 run=1", p, cnt, q, running);
      end
    end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_stop_start();
    int cnt;
    prescale = 0; periodic = 1; load = 1; load_value = 10;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      if (q == 6) break;
      step();
    end
    stop = 1;
    step();
    stop = 0;
    n_tests++;
    if (q !== 6 || running !== 1'b0) begin
      n_fail++; $display("FAIL stop_hold: got q=%0d run=%b, want q=6 run=0", q, running);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (q !== 6 || running !== 1'b0) begin
        n_fail++; $display("FAIL stop_idle %0d: got q=%0d run=%b, want q=6 run=0", i, q, running);
      end
    end
    start = 1;
    step();
    start = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(); cnt++;
      if (expired) break;
    end
    n_tests++;
    if (cnt !== 7 || q !== 10) begin
      n_fail++; $display("FAIL restart_expire: got cycles=%0d q=%0d, want cycles=7 q=10", cnt, q);
    end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_collisions();
    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_idle: got run=%b, want run=0", running);
    end
    prescale = 0; periodic = 1; load = 1; load_value = 1;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    step();
    load = 1; load_value = 7;
    step();
    load = 0;
    n_tests++;
    if (q !== 7 || expired !== 1'b0 || running !== 1'b1) begin
      n_fail++; $display("FAIL load_on_terminal: got q=%0d exp=%b run=%b, want q=7 exp=0 run=1", q, expired, running);
    end
    step();
    n_tests++;
    if (q !== 6 || expired !== 1'b0) begin
      n_fail++; $display("FAIL after_load_collision: got q=%0d exp=%b, want q=6 exp=0", q, expired);
    end
    reset = 1;
    step();
    reset = 0;
    n_tests++;
    if ({q, running, expired, irq} !== {32'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_midcount: got q=%0d run=%b exp=%b irq=%b, want all 0", q, running, expired, irq);
    end
  endtask

  task automatic test_irq();
    int nexp;
    prescale = 0; periodic = 1; load = 1; load_value = 3;
    step();
    load = 0; start = 1;
    step();
    start = 0;
`ifdef DOWN_COUNTER_TIMER_STICKY_IRQ_EN
    for (int i = 0; i < 20; i++) begin
      step();
      if (expired) break;
    end
    n_tests++;
    if (irq !== 1'b1 || expired !== 1'b1) begin
      n_fail++; $display("FAIL irq_set: got irq=%b exp=%b, want irq=1 exp=1", irq, expired);
    end
    step(); step();
    n_tests++;
    if (irq !== 1'b1 || expired !== 1'b0) begin
      n_fail++; $display("FAIL irq_sticky: got irq=%b exp=%b, want irq=1 exp=0", irq, expired);
    end
    irq_clr = 1;
    step();
    irq_clr = 0;
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got irq=%b, want 0", irq);
    end
    step();
    n_tests++;
    if (irq !== 1'b1 || expired !== 1'b1) begin
      n_fail++; $display("FAIL irq_reset_on_expiry: got irq=%b exp=%b, want irq=1 exp=1", irq, expired);
    end
    step(); step(); step();
    irq_clr = 1;
    step();
    irq_clr = 0;
    n_tests++;
    if (irq !== 1'b1 || expired !== 1'b1) begin
      n_fail++; $display("FAIL irq_clr_vs_expiry: got irq=%b exp=%b, want irq=1 exp=1", irq, expired);
    end
`else
    nexp = 0;
    for (int i = 0; i < 20; i++) begin
      irq_clr = 1'($urandom_range(0, 1));
      step();
      if (expired) nexp++;
      n_tests++;
      if (irq !== expired) begin
        n_fail++; $display("FAIL irq_mirror %0d: got irq=%b, want %b", i, irq, expired);
      end
    end
    irq_clr = 0;
    n_tests++;
    if (nexp !== 5) begin
      n_fail++; $display("FAIL irq_mirror_count: got %0d expiries, want 5", nexp);
    end
`endif
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      load       = ($urandom_range(0, 15) == 0);
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 15) == 0);
      irq_clr    = ($urandom_range(0, 7) == 0);
      load_value = W'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) periodic = ~periodic;
      if ($urandom_range(0, 31) == 0) prescale = PW'($urandom_range(0, 3));
      step();
      n_tests++;
      if ({q, running, expired, irq} !== {m_q, (m_mode == M_RUN), m_exp, m_irq}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got q=%0d run=%b exp=%b irq=%b, want q=%0d run=%b exp=%b irq=%b",
                 i, q, running, expired, irq, m_q, (m_mode == M_RUN), m_exp, m_irq);
      end
    end
    reset = 0; load = 0; start = 0; stop = 0; irq_clr = 0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_prescale();
    test_stop_start();
    test_collisions();
    test_irq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
